bit1: RTL and testbench

- Registered magnitude comparator; WIDTH=1 default is a 1-bit comparator.
- Compares operands a and b every clock and presents four mutually consistent flags: eq, neq, big (a>b), sma (a<b).
- Also gives a one-cycle pulse when the comparison result changes.
- Leaf block used inside datapath/control logic wherever a synchronous compare result is needed.

---
 rtl/bit1.sv | 44 ++++
 tb/tb_bit1.sv | 103 ++++++++++
 2 files changed

// File: rtl/bit1.sv
// bit1: registered magnitude comparator with eq/neq/big/sma flags and a result-change pulse.
module bit1 #(
    parameter int WIDTH  = 1,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             neq,
    output logic             big,
    output logic             sma
    ,
    output logic             chg
);
    logic [WIDTH-1:0] flip, ka, kb;
    logic [2:0]       flags_d, flags_q;
    logic             chg_d, chg_q;
    // Inverting the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        flip            = '0;
        flip[WIDTH-1]   = (SIGNED != 0);
        ka              = a ^ flip;
        kb              = b ^ flip;
        flags_d         = {ka == kb, ka > kb, ka < kb};
        chg_d           = flags_d != flags_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 3'b000;
            chg_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            chg_q   <= chg_d;
        end
    end
    // neq stays low in the all-zero "no valid result" state.
    assign eq  = flags_q[2];
    assign big = flags_q[1];
    assign sma = flags_q[0];
    assign neq = flags_q[1] | flags_q[0];
    assign chg = chg_q;
endmodule

// File: tb/tb_bit1.sv
// tb_bit1: drives four comparator variants (1/8-bit, unsigned/signed) against an arithmetic reference model.
module tb_bit1;
    logic       clk = 1'b0;
    logic       rst;
    logic       a1, b1;
    logic [7:0] a8, b8;
    logic [3:0] eq, neq, big, sma, chg;
    logic [2:0] prev [4];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    bit1 #(.WIDTH(1), .SIGNED(0)) d0 (.clk(clk), .rst(rst), .a(a1), .b(b1),
        .eq(eq[0]), .neq(neq[0]), .big(big[0]), .sma(sma[0]), .chg(chg[0]));
    bit1 #(.WIDTH(1), .SIGNED(1)) d1 (.clk(clk), .rst(rst), .a(a1), .b(b1),
        .eq(eq[1]), .neq(neq[1]), .big(big[1]), .sma(sma[1]), .chg(chg[1]));
    bit1 #(.WIDTH(8), .SIGNED(0)) d2 (.clk(clk), .rst(rst), .a(a8), .b(b8),
        .eq(eq[2]), .neq(neq[2]), .big(big[2]), .sma(sma[2]), .chg(chg[2]));
    bit1 #(.WIDTH(8), .SIGNED(1)) d3 (.clk(clk), .rst(rst), .a(a8), .b(b8),
        .eq(eq[3]), .neq(neq[3]), .big(big[3]), .sma(sma[3]), .chg(chg[3]));

    function automatic int val(int raw, int w, bit s);
        return (s && raw >= (1 << (w - 1))) ? raw - (1 << w) : raw;
    endfunction

    task automatic chk(string tag, int i, logic [4:0] obs, logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d {eq,neq,big,sma,chg} got=%b exp=%b", tag, i, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        for (int i = 0; i < 4; i++) begin
            int w, x, y;
            logic [2:0] f;
            w = (i < 2) ? 1 : 8;
            x = val((i < 2) ? int'(a1) : int'(a8), w, i[0]);
            y = val((i < 2) ? int'(b1) : int'(b8), w, i[0]);
            f = {x == y, x > y, x < y};
            chk(tag, i, {eq[i], neq[i], big[i], sma[i], chg[i]},
                {f[2], ~f[2], f[1], f[0], f != prev[i]});
            prev[i] = f;
        end
    endtask

    task automatic reset_check(string tag);
        for (int i = 0; i < 4; i++) begin
            chk(tag, i, {eq[i], neq[i], big[i], sma[i], chg[i]}, 5'b00000);
            prev[i] = 3'b000;
        end
    endtask

    task automatic drive(logic x1, logic y1, logic [7:0] x8, logic [7:0] y8);
        @(negedge clk);
        a1 = x1; b1 = y1; a8 = x8; b8 = y8;
    endtask

    task automatic step(string tag);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b0; a1 = 1'b1; b1 = 1'b0; a8 = 8'h80; b8 = 8'h7F;
        #1 rst = 1'b1;
        #1 reset_check("reset_async");
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        step("equal");
        step("equal_hold");
        drive(1'b1, 1'b0, 8'h80, 8'h7F);
        step("greater");
        drive(1'b0, 1'b1, 8'h7F, 8'h80);
        step("less");
        for (int n = 0; n < 100; n++) begin
            drive(1'((n / 2) % 2), 1'((n / 3) % 2), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            step("sweep");
        end
        for (int n = 0; n < 60; n++) begin
            logic [7:0] r;
            r = 8'($urandom_range(0, 255));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r,
                  ($urandom_range(0, 3) == 0) ? r : 8'($urandom_range(0, 255)));
            step("random");
        end
        drive(1'b1, 1'b0, 8'd5, 8'd3);
        step("pre_reset");
        #2 rst = 1'b1;
        #1 reset_check("mid_reset");
        @(posedge clk);
        #1 reset_check("reset_hold");
        drive(1'b1, 1'b0, 8'd5, 8'd3);
        rst = 1'b0;
        step("post_reset");
        step("post_reset_hold");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
